// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU load/store path and the debug/loader port.
// Round-robin grant, fixed MEM_LAT access window, one-cycle ack per transaction.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | sample requests, grant one, latch its command
// S_ACCESS | memory held for MEM_LAT cycles, down-counter to terminal 0
// S_RESP   | owner's ack pulses, rdata/err valid, then back to idle
module dmem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_size,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_xfer_size,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic              last_grant;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_size;
  logic              cpu_err_q;
  logic              dbg_err_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic              grant_cpu;
  logic              grant_dbg;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_size;
  logic              size_ok;
  logic              misaligned;
  logic              sel_err;
  logic              in_access;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_cpu  = cpu_req & (~dbg_req | (last_grant == OWN_DBG));
    grant_dbg  = dbg_req & ~grant_cpu;
    sel_we     = grant_cpu ? cpu_we    : dbg_we;
    sel_addr   = grant_cpu ? cpu_addr  : dbg_addr;
    sel_wdata  = grant_cpu ? cpu_wdata : dbg_wdata;
    sel_size   = grant_cpu ? cpu_size  : 4'd8;
    size_ok    = (sel_size == 4'd1) || (sel_size == 4'd2) ||
                 (sel_size == 4'd4) || (sel_size == 4'd8);
    misaligned = |(sel_addr[3:0] & (sel_size - 4'd1));
    sel_err    = ~size_ok | misaligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      owner       <= OWN_CPU;
      last_grant  <= OWN_DBG;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_size    <= '0;
      cpu_err_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_cpu || grant_dbg) begin
            owner      <= grant_dbg ? OWN_DBG : OWN_CPU;
            last_grant <= grant_dbg ? OWN_DBG : OWN_CPU;
            lat_we     <= sel_we;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_size   <= sel_size;
            if (sel_err) begin
              // Rejected requests never touch memory; report straight away.
              state <= S_RESP;
              if (grant_dbg) begin
                dbg_err_q   <= 1'b1;
                dbg_rdata_q <= '0;
              end else begin
                cpu_err_q   <= 1'b1;
                cpu_rdata_q <= '0;
              end
            end else begin
              state <= S_ACCESS;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state <= S_RESP;
            if (owner == OWN_DBG) begin
              dbg_err_q   <= 1'b0;
              dbg_rdata_q <= lat_we ? '0 : mem_read_data;
            end else begin
              cpu_err_q   <= 1'b0;
              cpu_rdata_q <= lat_we ? '0 : mem_read_data;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_access = (state == S_ACCESS);

  // Memory bus is quiet (all zero) outside the access window.
  assign mem_addr         = in_access ? lat_addr  : '0;
  assign mem_write_data   = in_access ? lat_wdata : '0;
  assign mem_xfer_size    = in_access ? lat_size  : 4'd0;
  assign mem_write_enable = in_access & lat_we & (cnt == CNT_INIT);
  assign mem_read_enable  = in_access & ~lat_we;

  assign cpu_ack   = (state == S_RESP) && (owner == OWN_CPU);
  assign dbg_ack   = (state == S_RESP) && (owner == OWN_DBG);
  assign cpu_err   = cpu_err_q;
  assign dbg_err   = dbg_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed sequencing scenarios plus randomized traffic,
// responses checked by a scoreboard against a byte-level memory reference model.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [63:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [3:0]  cpu_size;
  logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err;
  logic [63:0] cpu_rdata, dbg_rdata;
  logic [63:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_xfer_size;
  logic        mem_we, mem_re;

  logic        dbg2_req, dbg2_we;
  logic [63:0] dbg2_addr, dbg2_wdata;
  logic        dbg2_ack, dbg2_err;
  logic [63:0] dbg2_rdata;
  logic        c2_ack, c2_err, c2_stall;
  logic [63:0] c2_rdata;
  logic [63:0] mem2_addr, mem2_write_data, mem2_read_data;
  logic [3:0]  mem2_xfer_size;
  logic        mem2_we, mem2_re;

  int n_checks = 0;
  int n_errors = 0;

  sb_t  q_cpu[$];
  sb_t  q_dbg[$];
  sb_t  q_dbg2[$];
  logic grant_log[$];

  logic [7:0] mem1[logic [63:0]];
  logic [7:0] mem2[logic [63:0]];
  logic [7:0] ref1[logic [63:0]];
  logic [7:0] ref2[logic [63:0]];

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_xfer_size(mem_xfer_size),
    .mem_write_enable(mem_we), .mem_read_enable(mem_re), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut2 (
    .clk(clk), .reset(reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(64'd0), .cpu_wdata(64'd0),
    .cpu_size(4'd0), .cpu_ack(c2_ack), .cpu_err(c2_err), .cpu_rdata(c2_rdata),
    .cpu_stall(c2_stall),
    .dbg_req(dbg2_req), .dbg_we(dbg2_we), .dbg_addr(dbg2_addr), .dbg_wdata(dbg2_wdata),
    .dbg_ack(dbg2_ack), .dbg_err(dbg2_err), .dbg_rdata(dbg2_rdata),
    .mem_addr(mem2_addr), .mem_write_data(mem2_write_data), .mem_xfer_size(mem2_xfer_size),
    .mem_write_enable(mem2_we), .mem_read_enable(mem2_re), .mem_read_data(mem2_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Little-endian byte memories standing in for the data memory.
  function automatic logic [63:0] mem_rd(input int m, input logic [63:0] a, input logic [3:0] sz);
    logic [63:0] d = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(sz)) begin
        if (m == 1 && mem1.exists(a + 64'(i))) d[8*i +: 8] = mem1[a + 64'(i)];
        if (m == 2 && mem2.exists(a + 64'(i))) d[8*i +: 8] = mem2[a + 64'(i)];
      end
    end
    return d;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_we && i < int'(mem_xfer_size))
        mem1[mem_addr + 64'(i)] = mem_write_data[8*i +: 8];
      if (mem2_we && i < int'(mem2_xfer_size))
        mem2[mem2_addr + 64'(i)] = mem2_write_data[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    mem_read_data  = mem_rd(1, mem_addr, mem_xfer_size);
    mem2_read_data = mem_rd(2, mem2_addr, mem2_xfer_size);
  end

  // Reference: a transfer is legal for sizes 1/2/4/8 at a size-aligned address;
  // stores update the byte array, loads return the addressed bytes zero-extended.
  function automatic sb_t model(input int p, input logic we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [3:0] size);
    sb_t e;
    int  n = int'(size);
    e.err   = 1'b1;
    e.rdata = '0;
    if (n == 1 || n == 2 || n == 4 || n == 8) begin
      if ((addr % 64'(n)) == 64'd0) begin
        e.err = 1'b0;
        for (int i = 0; i < n; i++) begin
          if (we) begin
            if (p == 2) ref2[addr + 64'(i)] = wdata[8*i +: 8];
            else        ref1[addr + 64'(i)] = wdata[8*i +: 8];
          end else begin
            if (p == 2 && ref2.exists(addr + 64'(i))) e.rdata[8*i +: 8] = ref2[addr + 64'(i)];
            if (p != 2 && ref1.exists(addr + 64'(i))) e.rdata[8*i +: 8] = ref1[addr + 64'(i)];
          end
        end
      end
    end
    return e;
  endfunction

  // Monitor: pops the owner's expectation whenever an ack is presented.
  always @(negedge clk) begin
    sb_t e;
    if (cpu_ack || dbg_ack) chk("ack_overlap", 64'(cpu_ack & dbg_ack), 64'd0);
    if (cpu_ack) begin
      grant_log.push_back(1'b0);
      if (q_cpu.size() == 0) chk("cpu_unexpected_ack", 64'd1, 64'd0);
      else begin
        e = q_cpu.pop_front();
        chk("cpu_err", 64'(cpu_err), 64'(e.err));
        if (!e.err) chk("cpu_rdata", cpu_rdata, e.rdata);
      end
    end
    if (dbg_ack) begin
      grant_log.push_back(1'b1);
      if (q_dbg.size() == 0) chk("dbg_unexpected_ack", 64'd1, 64'd0);
      else begin
        e = q_dbg.pop_front();
        chk("dbg_err", 64'(dbg_err), 64'(e.err));
        if (!e.err) chk("dbg_rdata", dbg_rdata, e.rdata);
      end
    end
    if (dbg2_ack) begin
      if (q_dbg2.size() == 0) chk("dbg2_unexpected_ack", 64'd1, 64'd0);
      else begin
        e = q_dbg2.pop_front();
        chk("dbg2_err", 64'(dbg2_err), 64'(e.err));
        if (!e.err) chk("dbg2_rdata", dbg2_rdata, e.rdata);
      end
    end
  end

  // One transaction on port p (0=cpu, 1=dbg, 2=dbg of MEM_LAT=1 instance).
  // Call just after a rising edge; that cycle is cycle 0.
  task automatic txn(input int p, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [3:0] size,
                     output int ack_cyc, output logic [31:0] wem,
                     output logic [31:0] rem, output logic [31:0] stm);
    sb_t  e;
    logic a;
    e = model(p, we, addr, wdata, size);
    ack_cyc = -1;
    wem = '0; rem = '0; stm = '0;
    case (p)
      0: begin
        q_cpu.push_back(e);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_size = size; cpu_req = 1'b1;
      end
      1: begin
        q_dbg.push_back(e);
        dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
      end
      default: begin
        q_dbg2.push_back(e);
        dbg2_we = we; dbg2_addr = addr; dbg2_wdata = wdata; dbg2_req = 1'b1;
      end
    endcase
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      a      = (p == 0) ? cpu_ack : (p == 1) ? dbg_ack : dbg2_ack;
      wem[c] = (p == 2) ? mem2_we : mem_we;
      rem[c] = (p == 2) ? mem2_re : mem_re;
      stm[c] = cpu_stall;
      if (a) ack_cyc = c;
      @(posedge clk); #1;
      if (ack_cyc >= 0) break;
    end
    case (p)
      0:       cpu_req = 1'b0;
      1:       dbg_req = 1'b0;
      default: dbg2_req = 1'b0;
    endcase
    if (ack_cyc < 0) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu_random(input int n);
    int ac, sel;
    logic [31:0] w, r, s;
    logic [3:0] sz;
    logic [63:0] addr;
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    sz = 4'd1;
        2, 3:    sz = 4'd2;
        4, 5:    sz = 4'd4;
        6, 7:    sz = 4'd8;
        8:       sz = 4'd3;
        default: sz = 4'($urandom_range(0, 15));
      endcase
      addr = 64'($urandom_range(0, 56));
      if ($urandom_range(0, 4) != 0 && (sz == 1 || sz == 2 || sz == 4 || sz == 8))
        addr = addr & ~(64'(sz) - 64'd1);
      txn(0, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, sz, ac, w, r, s);
      idle_cycles($urandom_range(0, 3));
    end
  endtask

  task automatic dbg_random(input int n);
    int ac;
    logic [31:0] w, r, s;
    logic [63:0] addr;
    for (int k = 0; k < n; k++) begin
      addr = 64'h100 + 64'(8 * $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) addr = addr + 64'($urandom_range(1, 7));
      txn(1, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, 4'd8, ac, w, r, s);
      idle_cycles($urandom_range(0, 3));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac;
    logic [31:0] w, r, s;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    dbg2_req = 0; dbg2_we = 0; dbg2_addr = 0; dbg2_wdata = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_acks_err", 64'({cpu_ack, dbg_ack, cpu_err, dbg_err, cpu_stall}), 64'd0);
    chk("reset_mem_en", 64'({mem_we, mem_re, mem2_we, mem2_re}), 64'd0);
    chk("reset_mem_bus", mem_addr | mem_write_data | 64'(mem_xfer_size), 64'd0);
    chk("reset_rdata", cpu_rdata | dbg_rdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // CPU store then load of the same doubleword
    txn(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 4'd8, ac, w, r, s);
    chk("t1_ack_cycle", 64'(ac), 64'd3);
    chk("t1_we_cycles", 64'(w), 64'h2);
    chk("t1_re_cycles", 64'(r), 64'h0);
    chk("t1_stall_cycles", 64'(s), 64'h7);
    txn(0, 1'b0, 64'h10, 64'd0, 4'd8, ac, w, r, s);
    chk("t2_ack_cycle", 64'(ac), 64'd3);
    chk("t2_re_cycles", 64'(r), 64'h6);
    chk("t2_we_cycles", 64'(w), 64'h0);

    // Misaligned and illegal size are rejected without touching memory
    txn(0, 1'b0, 64'h13, 64'd0, 4'd8, ac, w, r, s);
    chk("t4a_ack_cycle", 64'(ac), 64'd1);
    chk("t4a_mem_en", 64'(w | r), 64'd0);
    txn(0, 1'b0, 64'h0, 64'd0, 4'd3, ac, w, r, s);
    chk("t4b_ack_cycle", 64'(ac), 64'd1);
    chk("t4b_mem_en", 64'(w | r), 64'd0);

    // Both requesting from reset: CPU first, then strict alternation
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    grant_log.delete();
    fork
      begin
        txn(0, 1'b1, 64'h40, 64'h1111_2222_3333_4444, 4'd8, ac, w, r, s);
        txn(0, 1'b1, 64'h48, 64'h5555_6666_7777_8888, 4'd8, ac, w, r, s);
      end
      begin
        int ac2;
        logic [31:0] w2, r2, s2;
        txn(1, 1'b1, 64'h140, 64'hAAAA_BBBB_CCCC_DDDD, 4'd8, ac2, w2, r2, s2);
        txn(1, 1'b1, 64'h148, 64'h0123_4567_89AB_CDEF, 4'd8, ac2, w2, r2, s2);
      end
    join
    chk("t3_grant_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4)
      chk("t3_grant_order", 64'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 64'h5);

    // Reset during the second access cycle of a store drops the transaction
    txn(0, 1'b0, 64'h10, 64'd0, 4'd8, ac, w, r, s);
    cpu_we = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'h0BAD_F00D_1234_5678; cpu_size = 4'd8;
    cpu_req = 1'b1;
    idle_cycles(2);
    reset = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_post_reset_outputs",
        64'({cpu_ack, cpu_err, mem_we, mem_re, cpu_stall}) | mem_addr | 64'(mem_xfer_size), 64'd0);
    chk("t5_post_reset_rdata", cpu_rdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(3);
    txn(0, 1'b1, 64'h20, 64'h0BAD_F00D_1234_5678, 4'd8, ac, w, r, s);
    chk("t5_rerequest_ack_cycle", 64'(ac), 64'd3);
    chk("t5_rerequest_we_cycles", 64'(w), 64'h2);
    txn(0, 1'b0, 64'h20, 64'd0, 4'd8, ac, w, r, s);

    // Randomized concurrent traffic in disjoint address regions
    fork
      cpu_random(40);
      dbg_random(40);
    join

    // MEM_LAT=1 instance: debug write then read back
    txn(2, 1'b1, 64'h8, 64'h7654_3210_FEDC_BA98, 4'd8, ac, w, r, s);
    chk("t6_write_ack_cycle", 64'(ac), 64'd2);
    chk("t6_write_we_cycles", 64'(w), 64'h2);
    txn(2, 1'b0, 64'h8, 64'd0, 4'd8, ac, w, r, s);
    chk("t6_read_ack_cycle", 64'(ac), 64'd2);
    chk("t6_read_re_cycles", 64'(r), 64'h2);

    idle_cycles(4);
    chk("cpu_queue_drained", 64'(q_cpu.size()), 64'd0);
    chk("dbg_queue_drained", 64'(q_dbg.size()), 64'd0);
    chk("dbg2_queue_drained", 64'(q_dbg2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
